fcs_checker: RTL and testbench
==============================

Name: fcs_checker

Overview:
- Receive-side Frame Check Sequence (FCS) checker: the far end of the serial FCS generator.
- Shifts serial frame bits (data field, then the 16-bit FCS appended by the transmitter) through a CRC-16 LFSR.
- Generator polynomial is x^16+x^12+x^5+1, MSB first, initial value 0x0000, no final XOR.
- Reports pass/fail per frame; a zero residue means pass.
- Sits between the serial receive deframer and the frame accept/discard logic.

Parameters:
FCS_WIDTH, 16, width of FCS/remainder; the polynomial taps are fixed for 16.
ERR_CNT_WIDTH, 8, width of the bad-frame counter (optional feature only).

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
Enable  input  1  block enable; low forces IDLE and clears Rem (synchronous)
Rx_Data  input  1  serial frame bit, MSB first
Rx_Valid  input  1  Rx_Data qualifier; low = stall, all state held
Frame_Start  input  1  high with Rx_Valid on the first data bit of a frame
Frame_End  input  1  high with Rx_Valid on the last data bit (before FCS)
Rem  output  FCS_WIDTH  running CRC remainder
Rx_Fcs  output  FCS_WIDTH  captured received FCS field
Busy  output  1  high in DATA or FCS state
Check_Done  output  1  one-cycle pulse, verdict valid
FCS_Ok  output  1  level: last frame passed
FCS_Err  output  1  level: last frame failed
Err_Cnt  output  ERR_CNT_WIDTH  bad-frame count (only with FCS_ERR_CNT_EN)

Behaviour:
- Reset: state=IDLE; Rem, Rx_Fcs, Err_Cnt=0; Busy, Check_Done, FCS_Ok, FCS_Err=0.
- LFSR step on each accepted bit d:
  - fb = Rem[15]^d.
  - Rem <= {Rem[14:12], Rem[11]^fb, Rem[10:5], Rem[4]^fb, Rem[3:0], fb}.
- States are IDLE, DATA, FCS and DONE:
  - IDLE: on Rx_Valid & Frame_Start, step the LFSR from seed 0 with the bit, clear FCS_Ok/FCS_Err/Rx_Fcs, then go to DATA. If Frame_End is also high (1-bit data field), go to FCS instead.
  - DATA: step on each Rx_Valid. On Rx_Valid & Frame_End, go to FCS with bit counter = 0.
  - FCS: on each Rx_Valid, step the LFSR, shift the bit into Rx_Fcs LSB (Rx_Fcs <= {Rx_Fcs[14:0], d}) and increment the 4-bit counter. The bit accepted at counter==15 moves the state to DONE.
  - DONE (one cycle): Check_Done=1. FCS_Ok=(Rem==0), FCS_Err=~FCS_Ok; both hold until the next Frame_Start, reset or Enable low. Then go to IDLE.
- Latency: verdict is registered and visible the cycle after the 16th FCS bit is accepted.
- Stalls: Rx_Valid low freezes state, counter, Rem and Rx_Fcs in every state. Data on a stall cycle is ignored.
- Frame_Start with Rx_Valid in DATA or FCS aborts the current frame:
  - no Check_Done and no verdict for the aborted frame;
  - the new frame restarts with the LFSR re-seeded to 0 and stepped with the current bit.
- Frame_Start in DONE is ignored; the sender guarantees at least one gap cycle.
- Frame_End outside DATA is ignored.
- Enable low: state=IDLE and Rem=0 next cycle. Check_Done is suppressed; FCS_Ok/FCS_Err are cleared. Err_Cnt is retained.
- Async reset mid-frame: all outputs return to reset values immediately; the frame is lost.
- Rem stays observable after DONE until the next frame start.

Optional Feature:
- Macro: FCS_ERR_CNT_EN.
- Defined: Err_Cnt increments by 1 on each DONE with a nonzero Rem and saturates at all-ones (no wrap). It is cleared only by reset.
- Undefined: the Err_Cnt port and its counter logic are absent, and all other behaviour is unchanged.

Test Plan:
- Good frame: "123456789" ASCII (72 bits, MSB first) followed by FCS 0x31C3 -> Rx_Fcs=0x31C3, Rem=0x0000, Check_Done pulses once, FCS_Ok=1, FCS_Err=0.
- Corruption: same frame with bit 0 of byte '5' inverted -> FCS_Err=1, FCS_Ok=0, Rem!=0; with FCS_ERR_CNT_EN, Err_Cnt 0->1.
- Stalls: good frame with Rx_Valid low on every third cycle -> identical result to case 1; Check_Done comes after the last valid FCS bit.
- Abort: Frame_Start reasserted after 40 data bits, then a full good frame -> exactly one Check_Done and FCS_Ok=1.
- Reset/Enable: RST low midway through the FCS field -> all outputs 0 immediately; Enable low mid-frame -> IDLE, no Check_Done.
- Saturation (FCS_ERR_CNT_EN, ERR_CNT_WIDTH=2): 5 bad frames -> Err_Cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/fcs_checker.sv
// Receive-side CRC-16 (x^16+x^12+x^5+1, MSB first, seed 0) frame checker.
// Ports: CLK/RST, Enable, Rx_* serial in; Rem, Rx_Fcs, Busy, Check_Done,
//   FCS_Ok, FCS_Err out; Err_Cnt only when FCS_ERR_CNT_EN is defined.
module fcs_checker #(
  parameter int FCS_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Enable,
  input  logic                 Rx_Data,
  input  logic                 Rx_Valid,
  input  logic                 Frame_Start,
  input  logic                 Frame_End,
  output logic [FCS_WIDTH-1:0] Rem,
  output logic [FCS_WIDTH-1:0] Rx_Fcs,
  output logic                 Busy,
  output logic                 Check_Done,
  output logic                 FCS_Ok,
`ifdef FCS_ERR_CNT_EN
  output logic                 FCS_Err,
  output logic [ERR_CNT_WIDTH-1:0] Err_Cnt
`else
  output logic                 FCS_Err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FCS,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [FCS_WIDTH-1:0] rem_q, rem_d;
  logic [FCS_WIDTH-1:0] fcs_q, fcs_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic                 start;
`ifdef FCS_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] ecnt_q, ecnt_d;
`endif

  // Taps at bits 12 and 5 plus the feedback into bit 0.
  function automatic logic [FCS_WIDTH-1:0] lfsr_step(
    input logic [FCS_WIDTH-1:0] r,
    input logic                 d
  );
    logic fb;
    fb = r[15] ^ d;
    return {r[14:12], r[11] ^ fb, r[10:5],
            r[4] ^ fb, r[3:0], fb};
  endfunction

  // A valid Frame_Start restarts from any state except DONE,
  // which also covers aborting a frame in DATA or FCS.
  assign start = Rx_Valid & Frame_Start & (state_q != DONE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fcs_d   = fcs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
`ifdef FCS_ERR_CNT_EN
    ecnt_d  = ecnt_q;
`endif
    if (!Enable) begin
      state_d = IDLE;
      rem_d   = '0;
      cnt_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else if (start) begin
      rem_d   = lfsr_step('0, Rx_Data);
      fcs_d   = '0;
      cnt_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      state_d = Frame_End ? FCS : DATA;
    end else begin
      unique case (state_q)
        IDLE: ;
        DATA: begin
          if (Rx_Valid) begin
            rem_d = lfsr_step(rem_q, Rx_Data);
            if (Frame_End) begin
              state_d = FCS;
              cnt_d   = '0;
            end
          end
        end
        FCS: begin
          if (Rx_Valid) begin
            rem_d = lfsr_step(rem_q, Rx_Data);
            fcs_d = {fcs_q[FCS_WIDTH-2:0], Rx_Data};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              // Verdict is taken from the post-step remainder so it
              // is registered together with the final Rem.
              state_d = DONE;
              done_d  = 1'b1;
              ok_d    = (rem_d == '0);
              err_d   = (rem_d != '0);
`ifdef FCS_ERR_CNT_EN
              if (rem_d != '0 && ecnt_q != '1)
                ecnt_d = ecnt_q + ERR_CNT_WIDTH'(1);
`endif
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == DATA) || (state_d == FCS);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      fcs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef FCS_ERR_CNT_EN
      ecnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fcs_q   <= fcs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
`ifdef FCS_ERR_CNT_EN
      ecnt_q  <= ecnt_d;
`endif
    end
  end

  assign Rem        = rem_q;
  assign Rx_Fcs     = fcs_q;
  assign Busy       = busy_q;
  assign Check_Done = done_q;
  assign FCS_Ok     = ok_q;
  assign FCS_Err    = err_q;
`ifdef FCS_ERR_CNT_EN
  assign Err_Cnt    = ecnt_q;
`endif

endmodule

// File: tb/tb_fcs_checker.sv
// Directed bench for fcs_checker: vector table plus corner sequences.
// Reference CRC is a byte-wise CRC-16/XMODEM model.
module tb_fcs_checker;

`ifdef FCS_ERR_CNT_EN
  localparam int ECW = 2;
`else
  localparam int ECW = 8;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        Enable;
  logic        Rx_Data;
  logic        Rx_Valid;
  logic        Frame_Start;
  logic        Frame_End;
  logic [15:0] Rem;
  logic [15:0] Rx_Fcs;
  logic        Busy;
  logic        Check_Done;
  logic        FCS_Ok;
  logic        FCS_Err;
`ifdef FCS_ERR_CNT_EN
  logic [ECW-1:0] Err_Cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int done_total = 0;
  int exp_ecnt = 0;

  fcs_checker #(.FCS_WIDTH(16), .ERR_CNT_WIDTH(ECW)) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable),
    .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid),
    .Frame_Start(Frame_Start), .Frame_End(Frame_End),
    .Rem(Rem), .Rx_Fcs(Rx_Fcs), .Busy(Busy),
    .Check_Done(Check_Done), .FCS_Ok(FCS_Ok),
`ifdef FCS_ERR_CNT_EN
    .FCS_Err(FCS_Err), .Err_Cnt(Err_Cnt)
`else
    .FCS_Err(FCS_Err)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (Check_Done === 1'b1) done_total++;

  typedef struct {
    logic [127:0] data;
    int           nb;
    logic [15:0]  fcs;
    bit           fcs_model;
    int           stall;
    int           flip_byte;
    bit           fe_in_fcs;
    bit           exp_ok;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                           input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_data(input logic [127:0] d,
                                           input int nb);
    logic [15:0] c;
    c = 16'h0000;
    for (int k = 0; k < nb; k++)
      c = crc_byte(c, d[127-8*k -: 8]);
    return c;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    Rx_Valid    = 1'b0;
    Rx_Data     = 1'b0;
    Frame_Start = 1'b0;
    Frame_End   = 1'b0;
  endtask

  task automatic drive(input logic d, input logic fs, input logic fe);
    Rx_Data     = d;
    Frame_Start = fs;
    Frame_End   = fe;
    Rx_Valid    = 1'b1;
    tick();
  endtask

  // Stall cycles carry junk data and control that must be ignored.
  task automatic stall_cyc();
    Rx_Valid    = 1'b0;
    Rx_Data     = 1'($urandom_range(0, 1));
    Frame_Start = 1'b1;
    Frame_End   = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [127:0] d, input int nb,
                            input logic [15:0] fcs, input int stall,
                            input int fcs_bits, input bit fe_fcs);
    int k;
    k = 0;
    for (int i = 0; i < nb * 8; i++) begin
      if (stall >= 2 && k > 0 && (k % (stall - 1)) == 0) stall_cyc();
      drive(d[127-i], i == 0, i == nb * 8 - 1);
      k++;
    end
    for (int j = 0; j < fcs_bits; j++) begin
      if (stall >= 2 && (k % (stall - 1)) == 0) stall_cyc();
      drive(fcs[15-j], 1'b0, fe_fcs);
      k++;
    end
    idle_in();
  endtask

  logic [127:0] good;
  logic [127:0] d;
  logic [15:0]  fcs;
  logic [15:0]  res;
  int           base;

  task automatic run_vec(input int i, input vec_t v);
    d = v.data;
    if (v.flip_byte >= 0)
      d[120-8*v.flip_byte] = ~d[120-8*v.flip_byte];
    fcs = v.fcs_model ? crc_data(d, v.nb) : v.fcs;
    res = crc_byte(crc_byte(crc_data(d, v.nb), fcs[15:8]), fcs[7:0]);
    base = done_total;
    send_frame(d, v.nb, fcs, v.stall, 16, v.fe_in_fcs);
    if (!v.exp_ok && exp_ecnt < (1 << ECW) - 1) exp_ecnt++;
    chk($sformatf("v%0d_done", i), 32'(Check_Done), 32'd1);
    chk($sformatf("v%0d_ok", i), 32'(FCS_Ok), 32'(v.exp_ok));
    chk($sformatf("v%0d_err", i), 32'(FCS_Err), 32'(!v.exp_ok));
    chk($sformatf("v%0d_rxfcs", i), 32'(Rx_Fcs), 32'(fcs));
    chk($sformatf("v%0d_rem", i), 32'(Rem), 32'(res));
`ifdef FCS_ERR_CNT_EN
    chk($sformatf("v%0d_ecnt", i), 32'(Err_Cnt), 32'(exp_ecnt));
`endif
    tick();
    chk($sformatf("v%0d_pulses", i), 32'(done_total - base), 32'd1);
    chk($sformatf("v%0d_done_lo", i), 32'(Check_Done), 32'd0);
    chk($sformatf("v%0d_rem_hold", i), 32'(Rem), 32'(res));
  endtask

  initial begin
    good = {"123456789", 56'h0};
    vecs[0] = '{good, 9, 16'h31C3, 1'b0, 0, -1, 1'b0, 1'b1};
    vecs[1] = '{good, 9, 16'h31C3, 1'b0, 0, 4, 1'b0, 1'b0};
    vecs[2] = '{good, 9, 16'h31C3, 1'b0, 3, -1, 1'b0, 1'b1};
    vecs[3] = '{good, 9, 16'h31C2, 1'b0, 0, -1, 1'b0, 1'b0};
    vecs[4] = '{{16'hA53C, 112'h0}, 2, 16'h0, 1'b1, 2, -1, 1'b1, 1'b1};
    vecs[5] = '{128'h0, 1, 16'h0000, 1'b0, 0, -1, 1'b0, 1'b1};
    vecs[6] = '{good, 9, 16'h31C3, 1'b0, 3, 0, 1'b0, 1'b0};

    RST = 1'b0;
    Enable = 1'b1;
    idle_in();
    tick();
    tick();
    chk("rst_rem", 32'(Rem), 32'd0);
    chk("rst_rxfcs", 32'(Rx_Fcs), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Check_Done), 32'd0);
    chk("rst_ok", 32'(FCS_Ok), 32'd0);
    chk("rst_err", 32'(FCS_Err), 32'd0);
    RST = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

`ifdef FCS_ERR_CNT_EN
    run_vec(7, vecs[1]);
    run_vec(8, vecs[3]);
`endif

    // 1-bit data field: Frame_Start and Frame_End on the same bit.
    base = done_total;
    drive(1'b1, 1'b1, 1'b1);
    chk("one_busy", 32'(Busy), 32'd1);
    for (int j = 15; j >= 0; j--) drive(j == 12 || j == 5 || j == 0,
                                        1'b0, 1'b0);
    idle_in();
    chk("one_ok", 32'(FCS_Ok), 32'd1);
    chk("one_rxfcs", 32'(Rx_Fcs), 32'h1021);
    chk("one_rem", 32'(Rem), 32'd0);
    tick();
    chk("one_pulses", 32'(done_total - base), 32'd1);

    // Abort after 40 data bits, then a complete good frame.
    base = done_total;
    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 1)), i == 0, 1'b0);
    send_frame(good, 9, 16'h31C3, 0, 16, 1'b0);
    chk("abort_ok", 32'(FCS_Ok), 32'd1);
    chk("abort_rxfcs", 32'(Rx_Fcs), 32'h31C3);
    tick();
    tick();
    tick();
    chk("abort_pulses", 32'(done_total - base), 32'd1);
    chk("ok_held", 32'(FCS_Ok), 32'd1);

    // Enable low clears the verdict.
    Enable = 1'b0;
    tick();
    chk("en_clr_ok", 32'(FCS_Ok), 32'd0);
    chk("en_clr_err", 32'(FCS_Err), 32'd0);
    Enable = 1'b1;
    tick();

    // Enable low mid-frame drops the frame; the tail must not complete.
    base = done_total;
    send_frame(good, 9, 16'h31C3, 0, 4, 1'b0);
    chk("en_busy_pre", 32'(Busy), 32'd1);
    Enable = 1'b0;
    tick();
    chk("en_busy", 32'(Busy), 32'd0);
    chk("en_rem", 32'(Rem), 32'd0);
    Enable = 1'b1;
    fcs = 16'h31C3;
    for (int j = 4; j < 16; j++) drive(fcs[15-j], 1'b0, 1'b0);
    idle_in();
    tick();
    chk("en_pulses", 32'(done_total - base), 32'd0);
    chk("en_busy_tail", 32'(Busy), 32'd0);
    chk("en_ok_tail", 32'(FCS_Ok), 32'd0);

    // Asynchronous reset in the middle of the FCS field.
    send_frame(good, 9, 16'h31C3, 0, 8, 1'b0);
    chk("ar_busy_pre", 32'(Busy), 32'd1);
    chk("ar_rxfcs_pre", 32'(Rx_Fcs), 32'h0031);
    RST = 1'b0;
    #1;
    exp_ecnt = 0;
    chk("ar_rem", 32'(Rem), 32'd0);
    chk("ar_rxfcs", 32'(Rx_Fcs), 32'd0);
    chk("ar_busy", 32'(Busy), 32'd0);
    chk("ar_done", 32'(Check_Done), 32'd0);
    chk("ar_ok", 32'(FCS_Ok), 32'd0);
    chk("ar_err", 32'(FCS_Err), 32'd0);
`ifdef FCS_ERR_CNT_EN
    chk("ar_ecnt", 32'(Err_Cnt), 32'(exp_ecnt));
`endif
    tick();
    RST = 1'b1;
    tick();

    // Good frame after reset still checks out.
    run_vec(9, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
